hub75_scan_ctrl: RTL and testbench

Scan controller for the HUB75 LED panel. It walks row pairs and bit planes, fetches pixel pairs from a framebuffer read port, and shifts them into the panel. It then blanks, sets the row address, latches, and enables the display for a binary-weighted time per plane (binary code modulation, BCM). It drives the panel pins directly (r0..b1, addr, clk_out, latch, oe) and replaces the free-running test pattern generator.

---
 rtl/hub75_pkg.sv | 38 +++
 rtl/hub75_scan_ctrl_bcm_timer.sv | 35 +++
 rtl/hub75_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan controller.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOW     = 3'd2,
    ST_HIGH    = 3'd3,
    ST_BLANK   = 3'd4,
    ST_LATCH   = 3'd5,
    ST_DISPLAY = 3'd6
  } scan_state_e;

  // fb_rdata channel positions, in units of COLOR_BITS (r0 in the MSBs)
  localparam int unsigned R0_LSB = 5;
  localparam int unsigned G0_LSB = 4;
  localparam int unsigned B0_LSB = 3;
  localparam int unsigned R1_LSB = 2;
  localparam int unsigned G1_LSB = 1;
  localparam int unsigned B1_LSB = 0;

  localparam int unsigned FB_MAX_W = 96;
  localparam logic [FB_MAX_W-1:0] FB_ONE = FB_MAX_W'(1);

  function automatic logic [5:0] plane_bits(input logic [FB_MAX_W-1:0] rdata,
                                            input int unsigned color_bits,
                                            input int unsigned plane);
    logic [5:0] bits;
    bits[5] = |(rdata & (FB_ONE << (R0_LSB * color_bits + plane)));
    bits[4] = |(rdata & (FB_ONE << (G0_LSB * color_bits + plane)));
    bits[3] = |(rdata & (FB_ONE << (B0_LSB * color_bits + plane)));
    bits[2] = |(rdata & (FB_ONE << (R1_LSB * color_bits + plane)));
    bits[1] = |(rdata & (FB_ONE << (G1_LSB * color_bits + plane)));
    bits[0] = |(rdata & (FB_ONE << (B1_LSB * color_bits + plane)));
    return bits;
  endfunction

endpackage

// File: rtl/hub75_scan_ctrl_bcm_timer.sv
// BCM on-time timer: start loads BASE_ON<<plane, done marks the last on cycle.
module hub75_bcm_timer #(
  parameter int BASE_ON    = 8,
  parameter int COLOR_BITS = 4,
  parameter int PLANE_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PLANE_W-1:0] plane,
  output logic               done
);

  localparam int ON_W = $clog2(BASE_ON << (COLOR_BITS - 1)) + 1;
  localparam logic [ON_W-1:0] BASE   = ON_W'(BASE_ON);
  localparam logic [ON_W-1:0] ON_ONE = ON_W'(1);

  logic [ON_W-1:0] remain_r;

  // cycles left after the current one in the on-time window
  always_ff @(posedge clk) begin
    if (rst) begin
      remain_r <= '0;
    end else if (start) begin
      remain_r <= (BASE << plane) - ON_ONE;
    end else if (remain_r != '0) begin
      remain_r <= remain_r - ON_ONE;
    end else begin
      remain_r <= remain_r;
    end
  end

  assign done = (remain_r == '0);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: shifts pixel pairs per row/plane and drives BCM on-times.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS       = 64,
  parameter int ROW_ADDR_W = 5,
  parameter int COLOR_BITS = 4,
  parameter int CLK_DIV    = 2,
  parameter int LATCH_W    = 2,
  parameter int BASE_ON    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  output logic                                  fb_rd_en,
  output logic [ROW_ADDR_W+$clog2(COLS)-1:0]    fb_addr,
  input  logic [6*COLOR_BITS-1:0]               fb_rdata,
  output logic                                  r0,
  output logic                                  g0,
  output logic                                  b0,
  output logic                                  r1,
  output logic                                  g1,
  output logic                                  b1,
  output logic [ROW_ADDR_W-1:0]                 addr,
  output logic                                  clk_out,
  output logic                                  latch,
  output logic                                  oe,
  output logic                                  frame_start
);

  localparam int COL_W   = $clog2(COLS);
  localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int DIV_MAX = (CLK_DIV > LATCH_W) ? CLK_DIV : LATCH_W;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [COL_W-1:0]      LAST_COL   = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0]      COL_ONE    = COL_W'(1);
  localparam logic [PLANE_W-1:0]    LAST_PLANE = PLANE_W'(COLOR_BITS - 1);
  localparam logic [PLANE_W-1:0]    PLANE_ONE  = PLANE_W'(1);
  localparam logic [ROW_ADDR_W-1:0] ROW_ONE    = ROW_ADDR_W'(1);
  localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]      LATCH_LAST = DIV_W'(LATCH_W - 1);
  localparam logic [DIV_W-1:0]      DIV_ONE    = DIV_W'(1);

  scan_state_e             state_r;
  logic [ROW_ADDR_W-1:0]   row_r;
  logic [PLANE_W-1:0]      plane_r;
  logic [COL_W-1:0]        col_r;
  logic [DIV_W-1:0]        div_r;
  logic [5:0]              data_r;
  logic [ROW_ADDR_W-1:0]   next_row_s;
  logic [PLANE_W-1:0]      next_plane_s;
  logic [5:0]              pixel_s;
  logic                    start_s;
  logic                    done_s;

  assign pixel_s = plane_bits(FB_MAX_W'(fb_rdata), COLOR_BITS, 32'(plane_r));
  assign start_s = (state_r == ST_LATCH) && (div_r == LATCH_LAST);
  assign {r0, g0, b0, r1, g1, b1} = data_r;

  hub75_bcm_timer #(
    .BASE_ON    (BASE_ON),
    .COLOR_BITS (COLOR_BITS),
    .PLANE_W    (PLANE_W)
  ) u_bcm_timer (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .plane (plane_r),
    .done  (done_s)
  );

  // plane/row visited after the current on-time window
  always_comb begin
    next_row_s   = row_r;
    next_plane_s = plane_r;
    if (plane_r == LAST_PLANE) begin
      next_plane_s = '0;
      next_row_s   = row_r + ROW_ONE;
    end else begin
      next_plane_s = plane_r + PLANE_ONE;
    end
  end

  // scan sequencer: state, counters and every panel-facing register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      row_r       <= '0;
      plane_r     <= '0;
      col_r       <= '0;
      div_r       <= '0;
      data_r      <= '0;
      addr        <= '0;
      clk_out     <= 1'b0;
      latch       <= 1'b0;
      oe          <= 1'b1;
      fb_rd_en    <= 1'b0;
      fb_addr     <= '0;
      frame_start <= 1'b0;
    end else begin
      fb_rd_en    <= 1'b0;
      frame_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_r     <= ST_FETCH;
            row_r       <= '0;
            plane_r     <= '0;
            col_r       <= '0;
            fb_rd_en    <= 1'b1;
            fb_addr     <= '0;
            frame_start <= 1'b1;
          end
        end
        ST_FETCH: begin
          state_r <= ST_LOW;
          div_r   <= '0;
        end
        ST_LOW: begin
          // read data arrives one cycle after the strobe, i.e. now
          if (div_r == '0) begin
            data_r <= pixel_s;
          end
          if (div_r == DIV_LAST) begin
            state_r <= ST_HIGH;
            div_r   <= '0;
            clk_out <= 1'b1;
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        ST_HIGH: begin
          if (div_r == DIV_LAST) begin
            clk_out <= 1'b0;
            div_r   <= '0;
            if (col_r == LAST_COL) begin
              col_r   <= '0;
              state_r <= ST_BLANK;
              addr    <= row_r;
            end else begin
              col_r    <= col_r + COL_ONE;
              state_r  <= ST_FETCH;
              fb_rd_en <= 1'b1;
              fb_addr  <= {row_r, col_r + COL_ONE};
            end
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        ST_BLANK: begin
          state_r <= ST_LATCH;
          latch   <= 1'b1;
          div_r   <= '0;
        end
        ST_LATCH: begin
          if (div_r == LATCH_LAST) begin
            latch   <= 1'b0;
            oe      <= 1'b0;
            state_r <= ST_DISPLAY;
            div_r   <= '0;
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        ST_DISPLAY: begin
          if (done_s) begin
            oe <= 1'b1;
            if (enable) begin
              row_r       <= next_row_s;
              plane_r     <= next_plane_s;
              state_r     <= ST_FETCH;
              fb_rd_en    <= 1'b1;
              fb_addr     <= {next_row_s, {COL_W{1'b0}}};
              frame_start <= (next_row_s == '0) && (next_plane_s == '0);
            end else begin
              state_r <= ST_IDLE;
              row_r   <= '0;
              plane_r <= '0;
              col_r   <= '0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          oe      <= 1'b1;
          latch   <= 1'b0;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl: timing table, random-pattern model, corner sequences.
module tb_hub75_scan_ctrl;

  localparam int COLS = 4, ROW_ADDR_W = 1, COLOR_BITS = 2;
  localparam int CLK_DIV = 1, LATCH_W = 1, BASE_ON = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fb_rd_en;
  logic [2:0]  fb_addr;
  logic [11:0] fb_rdata = 12'h000;
  logic        r0, g0, b0, r1, g1, b1;
  logic [0:0]  addr;
  logic        clk_out, latch, oe, frame_start;

  int tests = 0;
  int fails = 0;
  int prints = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  hub75_scan_ctrl #(
    .COLS(COLS), .ROW_ADDR_W(ROW_ADDR_W), .COLOR_BITS(COLOR_BITS),
    .CLK_DIV(CLK_DIV), .LATCH_W(LATCH_W), .BASE_ON(BASE_ON)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .addr(addr), .clk_out(clk_out), .latch(latch), .oe(oe),
    .frame_start(frame_start)
  );

  // framebuffer: synchronous read, data valid the cycle after the strobe
  logic [11:0] fb_mem [8];
  always @(posedge clk) if (fb_rd_en) fb_rdata <= fb_mem[fb_addr];

  // ctl bit order: {oe, latch, clk_out, frame_start, fb_rd_en, addr}
  task automatic pin_chk(input string name, input logic [5:0] ctl, input logic chk_fa,
                         input logic [2:0] fa, input logic chk_d, input logic [5:0] d);
    logic [5:0] act_ctl, act_d;
    logic bad;
    act_ctl = {oe, latch, clk_out, frame_start, fb_rd_en, addr};
    act_d   = {r0, g0, b0, r1, g1, b1};
    bad = (act_ctl !== ctl) || (chk_fa && (fb_addr !== fa)) || (chk_d && (act_d !== d));
    tests++;
    if (bad) begin
      fails++;
      if (prints < 30) begin
        prints++;
        $display("FAIL %s @cyc %0d: got ctl=%b fb_addr=%0d data=%b, expected ctl=%b fb_addr=%0d data=%b",
                 name, cyc, act_ctl, fb_addr, act_d, ctl, fa, d);
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk_reset(input string name);
    pin_chk(name, 6'b100000, 1'b1, 3'd0, 1'b1, 6'd0);
  endtask

  // hold reset, check reset state, then release with enable=1 (next cycle is t=0)
  task automatic start_run();
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset_values");
    rst = 1'b0; enable = 1'b1;
    cyc = -1;
  endtask

  // panel-side invariants, checked on the falling edge
  logic prev_addr = 1'b0;
  always @(negedge clk) begin
    tests++;
    if ((latch === 1'b1) && (oe === 1'b0)) begin
      fails++;
      $display("FAIL latch_oe_overlap: got latch=%b oe=%b, expected not both active", latch, oe);
    end else if ((addr !== prev_addr) && (oe !== 1'b1)) begin
      fails++;
      $display("FAIL addr_change_while_on: got addr %b->%b with oe=%b, expected oe=1", prev_addr, addr, oe);
    end
    prev_addr = addr;
  end

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [5:0] ctl;
    logic       chk_fa;
    logic [2:0] fa;
    logic       chk_d;
    logic [5:0] d;
  } exp_t;

  exp_t       expq[$];
  logic       m_addr;
  logic [5:0] m_data;

  function automatic logic [5:0] plane_px(input logic [11:0] w, input int p);
    logic [5:0] b = 6'd0;
    for (int ch = 0; ch < 6; ch++)
      b = {b[4:0], |(w & (12'h001 << ((5 - ch) * COLOR_BITS + p)))};
    return b;
  endfunction

  function automatic void push(input logic o, input logic l, input logic c, input logic fs,
                               input logic rd, input logic [2:0] fa, input logic chk_d,
                               input logic [5:0] d);
    exp_t e;
    e.ctl = {o, l, c, fs, rd, m_addr};
    e.chk_fa = rd; e.fa = fa; e.chk_d = chk_d; e.d = d;
    expq.push_back(e);
  endfunction

  function automatic void gen_plane(input int row, input int p);
    logic [2:0] a;
    logic [5:0] px;
    for (int c = 0; c < COLS; c++) begin
      a  = 3'(row * COLS + c);
      px = plane_px(fb_mem[a], p);
      push(1'b1, 1'b0, 1'b0, (row == 0 && p == 0 && c == 0), 1'b1, a, 1'b0, 6'd0);
      for (int k = 0; k < CLK_DIV; k++) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, 1'b0, 6'd0);
      m_data = px;
      for (int k = 0; k < CLK_DIV; k++) push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a, 1'b1, px);
    end
    m_addr = 1'(row);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, m_data);
    for (int k = 0; k < LATCH_W; k++) push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, m_data);
    for (int k = 0; k < (BASE_ON << p); k++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, m_data);
  endfunction

  // ---------------- timing table ----------------
  typedef struct {
    int         t;
    logic [5:0] ctl;
    logic [2:0] fa;
    logic       chk_d;
    logic [5:0] d;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(input int t, input logic [5:0] ctl, input logic [2:0] fa,
                                  input logic chk_d, input logic [5:0] d);
    vec_t v;
    v.t = t; v.ctl = ctl; v.fa = fa; v.chk_d = chk_d; v.d = d;
    tbl.push_back(v);
  endfunction

  initial begin
    int vi;
    exp_t e;

    // r0 = 2'b10 everywhere: r0 low in plane 0, high in plane 1
    add_vec( 0, 6'b100110, 3'd0, 1'b0, 6'd0);
    add_vec( 1, 6'b100000, 3'd0, 1'b0, 6'd0);
    add_vec( 2, 6'b101000, 3'd0, 1'b1, 6'd0);
    add_vec( 3, 6'b100010, 3'd1, 1'b0, 6'd0);
    add_vec(11, 6'b101000, 3'd0, 1'b1, 6'd0);
    add_vec(12, 6'b100000, 3'd0, 1'b1, 6'd0);
    add_vec(13, 6'b110000, 3'd0, 1'b1, 6'd0);
    add_vec(14, 6'b000000, 3'd0, 1'b1, 6'd0);
    add_vec(15, 6'b000000, 3'd0, 1'b1, 6'd0);
    add_vec(16, 6'b100010, 3'd0, 1'b0, 6'd0);
    add_vec(18, 6'b101000, 3'd0, 1'b1, 6'b100000);
    add_vec(28, 6'b100000, 3'd0, 1'b1, 6'b100000);
    add_vec(29, 6'b110000, 3'd0, 1'b1, 6'b100000);
    add_vec(30, 6'b000000, 3'd0, 1'b1, 6'b100000);
    add_vec(33, 6'b000000, 3'd0, 1'b1, 6'b100000);
    add_vec(34, 6'b100010, 3'd4, 1'b0, 6'd0);
    add_vec(36, 6'b101000, 3'd0, 1'b1, 6'd0);
    add_vec(46, 6'b100001, 3'd0, 1'b1, 6'd0);
    add_vec(47, 6'b110001, 3'd0, 1'b1, 6'd0);
    add_vec(68, 6'b100111, 3'd0, 1'b0, 6'd0);
    add_vec(69, 6'b100001, 3'd0, 1'b0, 6'd0);

    for (int i = 0; i < 8; i++) fb_mem[i] = 12'h800;
    start_run();
    vi = 0;
    for (int t = 0; t <= 69; t++) begin
      step();
      if (vi < tbl.size() && tbl[vi].t == cyc) begin
        pin_chk($sformatf("vec_t%0d", tbl[vi].t), tbl[vi].ctl, tbl[vi].ctl[1],
                tbl[vi].fa, tbl[vi].chk_d, tbl[vi].d);
        vi++;
      end
    end

    // per-column pattern, then random framebuffers, two frames each against the model
    for (int pat = 0; pat < 3; pat++) begin
      for (int i = 0; i < 8; i++) begin
        logic [1:0] c;
        c = 2'(i);
        fb_mem[i] = (pat == 0) ? ({1'b0, c[0], 8'h00, 1'b0, c[1], 2'b00}) : 12'($urandom);
      end
      expq.delete();
      m_addr = 1'b0; m_data = 6'd0;
      for (int f = 0; f < 2; f++)
        for (int row = 0; row < 2; row++)
          for (int p = 0; p < COLOR_BITS; p++)
            gen_plane(row, p);
      start_run();
      while (expq.size() > 0) begin
        step();
        e = expq.pop_front();
        pin_chk($sformatf("model_p%0d", pat), e.ctl, e.chk_fa, e.fa, e.chk_d, e.d);
      end
    end

    // enable dropped mid plane-1 on-time: finish plane, idle, restart at frame start
    for (int i = 0; i < 8; i++) fb_mem[i] = 12'h000;
    start_run();
    run_to(31);
    pin_chk("drop_mid_on", 6'b000000, 1'b0, 3'd0, 1'b0, 6'd0);
    enable = 1'b0;
    run_to(32); pin_chk("drop_complete_a", 6'b000000, 1'b0, 3'd0, 1'b0, 6'd0);
    run_to(33); pin_chk("drop_complete_b", 6'b000000, 1'b0, 3'd0, 1'b0, 6'd0);
    run_to(34); pin_chk("drop_idle_a", 6'b100000, 1'b0, 3'd0, 1'b0, 6'd0);
    run_to(36); pin_chk("drop_idle_b", 6'b100000, 1'b0, 3'd0, 1'b0, 6'd0);
    enable = 1'b1;
    run_to(37); pin_chk("restart_frame", 6'b100110, 1'b1, 3'd0, 1'b0, 6'd0);
    run_to(50); pin_chk("restart_latch", 6'b110000, 1'b0, 3'd0, 1'b0, 6'd0);
    run_to(52); pin_chk("restart_plane0_on", 6'b000000, 1'b0, 3'd0, 1'b0, 6'd0);
    run_to(53); pin_chk("restart_plane0_end", 6'b100010, 1'b1, 3'd0, 1'b0, 6'd0);

    // reset asserted during LATCH, then during row-1 DISPLAY
    start_run();
    run_to(13);
    pin_chk("pre_rst_latch", 6'b110000, 1'b0, 3'd0, 1'b0, 6'd0);
    rst = 1'b1;
    step(); chk_reset("rst_in_latch");
    rst = 1'b0;
    cyc = -1;
    step(); pin_chk("restart_after_rst", 6'b100110, 1'b1, 3'd0, 1'b0, 6'd0);
    run_to(48);
    pin_chk("pre_rst_display", 6'b000001, 1'b0, 3'd0, 1'b0, 6'd0);
    rst = 1'b1;
    step(); chk_reset("rst_in_display");
    enable = 1'b0;
    step(); chk_reset("rst_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
